// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath types and width constants
package cpu_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int IMM_WIDTH  = 4;

   typedef enum logic [1:0] {
      BSEL_REG  = 2'b00,
      BSEL_IMM  = 2'b01,
      BSEL_SW   = 2'b10,
      BSEL_ZERO = 2'b11
   } bsel_t;

endpackage : cpu_pkg

// File: rtl/sign_extend.sv
// rtl/sign_extend.sv - combinational sign extension from IN_WIDTH to OUT_WIDTH
module sign_extend #(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = 8
) (
   input  logic [IN_WIDTH-1:0]  data_i,
   output logic [OUT_WIDTH-1:0] data_o
);

   // replicate the sign bit into every upper bit
   assign data_o = {{(OUT_WIDTH-IN_WIDTH){data_i[IN_WIDTH-1]}}, data_i};

endmodule : sign_extend

// File: rtl/b_mux.sv
// rtl/b_mux.sv - registered 4:1 operand selector driving the ALU B-bus
module b_mux #(
   parameter int WIDTH     = cpu_pkg::DATA_WIDTH,
   parameter int IMM_WIDTH = cpu_pkg::IMM_WIDTH
) (
   input  logic                 in_clk,
   input  logic                 in_rst_n,
   input  logic [1:0]           B_selMUX,
   input  logic [WIDTH-1:0]     bData,
   input  logic [IMM_WIDTH-1:0] bit_extend,
   input  logic [WIDTH-1:0]     inSwitch,
   output logic [WIDTH-1:0]     bBusMUX
);

   cpu_pkg::bsel_t   sel;
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] bbus_d;
   logic [WIDTH-1:0] bbus_q;

   assign sel = cpu_pkg::bsel_t'(B_selMUX);

   sign_extend #(
      .IN_WIDTH  (IMM_WIDTH),
      .OUT_WIDTH (WIDTH)
   ) u_imm_ext (
      .data_i (bit_extend),
      .data_o (imm_ext)
   );

   // pick exactly one source per select value; every encoding is defined
   always_comb begin
      bbus_d = '0;
      unique case (sel)
         cpu_pkg::BSEL_REG:  bbus_d = bData;
         cpu_pkg::BSEL_IMM:  bbus_d = imm_ext;
         cpu_pkg::BSEL_SW:   bbus_d = inSwitch;
         cpu_pkg::BSEL_ZERO: bbus_d = '0;
         default:            bbus_d = '0;
      endcase
   end

   // hold the operand for a full cycle; reset clears it without waiting for a clock
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         bbus_q <= '0;
      end else begin
         bbus_q <= bbus_d;
      end
   end

   assign bBusMUX = bbus_q;

endmodule : b_mux

// File: tb/tb_b_mux.sv
// tb/tb_b_mux.sv - self-checking bench for b_mux
module tb_b_mux;

   logic       in_clk;
   logic       in_rst_n;
   logic [1:0] B_selMUX;
   logic [7:0] bData;
   logic [3:0] bit_extend;
   logic [7:0] inSwitch;
   logic [7:0] bBusMUX;

   int passed;
   int total;

   logic [7:0] exp_q[$];

   typedef struct {
      string      name;
      logic [1:0] sel;
      logic [7:0] bd;
      logic [3:0] imm;
      logic [7:0] sw;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   b_mux dut (
      .in_clk     (in_clk),
      .in_rst_n   (in_rst_n),
      .B_selMUX   (B_selMUX),
      .bData      (bData),
      .bit_extend (bit_extend),
      .inSwitch   (inSwitch),
      .bBusMUX    (bBusMUX)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL %s: scoreboard empty, got %02h expected a queued value", name, bBusMUX);
      end else begin
         e = exp_q.pop_front();
         check(name, bBusMUX, e);
      end
   endtask

   task automatic apply(input string name, input logic [1:0] sel, input logic [7:0] bd,
                        input logic [3:0] imm, input logic [7:0] sw, input logic [7:0] exp);
      @(negedge in_clk);
      B_selMUX   = sel;
      bData      = bd;
      bit_extend = imm;
      inSwitch   = sw;
      exp_q.push_back(exp);
      @(posedge in_clk);
      #1;
      pop_check(name);
   endtask

   function automatic logic [7:0] model(input logic [1:0] sel, input logic [7:0] bd,
                                        input logic [3:0] imm, input logic [7:0] sw);
      int v;
      case (sel)
         2'd0: return bd;
         2'd1: begin
            v = int'(imm);
            if (v >= 8) v = v - 16;
            return v[7:0];
         end
         2'd2: return sw;
         default: return 8'h00;
      endcase
   endfunction

   initial begin
      logic [1:0] rs;
      logic [7:0] rb;
      logic [3:0] ri;
      logic [7:0] rw;
      passed = 0;
      total  = 0;

      vecs.push_back('{"reg_a0",     2'b00, 8'hA0, 4'h0, 8'h00, 8'hA0});
      vecs.push_back('{"imm_1111",   2'b01, 8'h00, 4'hF, 8'h00, 8'hFF});
      vecs.push_back('{"imm_1000",   2'b01, 8'h00, 4'h8, 8'h00, 8'hF8});
      vecs.push_back('{"imm_0111",   2'b01, 8'h00, 4'h7, 8'h00, 8'h07});
      vecs.push_back('{"sw_05",      2'b10, 8'h00, 4'h0, 8'h05, 8'h05});
      vecs.push_back('{"zero",       2'b11, 8'h5A, 4'hF, 8'hC3, 8'h00});
      vecs.push_back('{"b2b_reg",    2'b00, 8'hA0, 4'hF, 8'h05, 8'hA0});
      vecs.push_back('{"b2b_imm",    2'b01, 8'hA0, 4'hF, 8'h05, 8'hFF});
      vecs.push_back('{"b2b_sw",     2'b10, 8'hA0, 4'hF, 8'h05, 8'h05});
      vecs.push_back('{"b2b_zero",   2'b11, 8'hA0, 4'hF, 8'h05, 8'h00});

      // reset held while clocking, with a live switch value presented
      in_rst_n   = 1'b0;
      B_selMUX   = 2'b10;
      bData      = 8'h00;
      bit_extend = 4'h0;
      inSwitch   = 8'h05;
      #1;
      check("rst_t0", bBusMUX, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge in_clk);
         #1;
         check("rst_hold", bBusMUX, 8'h00);
      end
      @(negedge in_clk);
      in_rst_n = 1'b1;
      exp_q.push_back(8'h05);
      @(posedge in_clk);
      #1;
      pop_check("rst_release");

      // table vectors, applied on consecutive edges
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].name, vecs[i].sel, vecs[i].bd, vecs[i].imm, vecs[i].sw, vecs[i].exp);
      end

      // random vectors against an independent model
      for (int i = 0; i < 24; i++) begin
         rs = 2'($urandom_range(0, 3));
         rb = 8'($urandom);
         ri = 4'($urandom);
         rw = 8'($urandom);
         apply("random", rs, rb, ri, rw, model(rs, rb, ri, rw));
      end

      // input changes between edges must not reach the output
      apply("pre_hold", 2'b01, 8'h00, 4'hF, 8'h00, 8'hFF);
      B_selMUX = 2'b00;
      bData    = 8'h33;
      #1;
      check("hold_between_edges", bBusMUX, 8'hFF);

      // reset asserted mid-cycle clears the output before the next edge
      in_rst_n = 1'b0;
      #1;
      check("async_rst_mid", bBusMUX, 8'h00);
      @(posedge in_clk);
      #1;
      check("async_rst_edge", bBusMUX, 8'h00);
      @(negedge in_clk);
      in_rst_n = 1'b1;
      apply("post_rst_reg", 2'b00, 8'h3C, 4'h0, 8'h00, 8'h3C);

      if (exp_q.size() != 0) begin
         total++;
         $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule : tb_b_mux
